mtx_encoder: RTL and testbench
==============================

MTX_ENCODER -- requirements
Module: mtx_encoder

Interface
REQ-001 Parameter WIDTH, default 19, bit width of one matrix cell (real or imaginary part).
REQ-002 Parameter GAP, default 0, number of idle cycles (ready low) inserted between consecutive cells; range 0..255.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 matrix  input  [1:0][1:0][1:0] x WIDTH  source matrix, indexed [imag][row][col].
REQ-006 start  input  1  request to transmit matrix; accepted only when busy is low.
REQ-007 busy  output  1  high while a transmission is in progress.
REQ-008 matrix_cell  output  WIDTH  cell value on the serial link.
REQ-009 imag  output  1  high = imaginary part, low = real part of the current cell.
REQ-010 row  output  1  row index of the current cell.
REQ-011 col  output  1  column index of the current cell.
REQ-012 ready  output  1  qualifies matrix_cell/imag/row/col for one cycle.
REQ-013 new_mtx  output  1  one-cycle pulse announcing the start of a new matrix.
REQ-014 done  output  1  one-cycle pulse after the eighth cell has been sent.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 FSM states: IDLE, ANNOUNCE, SEND, WAIT, FINISH.
REQ-017 IDLE: on start=1, SHALL go to ANNOUNCE at the next edge; busy rises in the same edge.
REQ-018 ANNOUNCE: new_mtx=1 and ready=0 for exactly one cycle; then SEND with cell index k=0.
REQ-019 SEND: one cycle, ready=1; {imag,row,col}=k[2:0] (k=4*imag+2*row+col); matrix_cell=matrix[imag][row][col].
REQ-020 After SEND with k<7: if GAP=0 go to SEND with k+1; otherwise WAIT for exactly GAP cycles (ready=0), then SEND with k+1.
REQ-021 After SEND with k=7: go to FINISH; FINISH asserts done=1 for one cycle; busy falls at the edge leaving FINISH; return to IDLE.
REQ-022 Latency with GAP=0: start accepted at edge N -> new_mtx at N+1, cells at N+2..N+9, done at N+10; total 10 cycles busy.
REQ-023 General busy duration: 10 + 7*GAP cycles.
REQ-024 new_mtx and ready SHALL never be high in the same cycle.
REQ-025 start while busy=1, including during FINISH, SHALL be ignored; back-to-back requires start in IDLE (minimum 1 idle cycle between transmissions).
REQ-026 While ready=0, matrix_cell/imag/row/col SHALL hold their last values (no toggling on idle cycles).
REQ-027 GAP counter SHALL be 8 bits and SHALL not wrap; GAP=0 bypasses WAIT entirely.

Reset
REQ-028 reset=1 SHALL force IDLE, k=0, GAP counter=0, and busy, ready, new_mtx, done, imag, row, col, matrix_cell all 0 at the next edge.
REQ-029 reset mid-transmission SHALL abort without emitting further cells or done; a subsequent start SHALL begin with a fresh new_mtx pulse.
REQ-030 reset has priority over start in the same cycle.

Configuration
REQ-031 Macro MTX_ENCODER_SNAPSHOT_EN: when defined, the full matrix SHALL be captured into internal registers on the edge that accepts start, and all eight cells SHALL be sent from the snapshot regardless of later matrix changes.
REQ-032 Without MTX_ENCODER_SNAPSHOT_EN: no capture registers; each cell SHALL be sampled from the live matrix input in its SEND cycle, and the source SHALL hold matrix stable while busy=1.

Structure
REQ-033 A shared package SHALL hold the cell width constant (19), the REAL=0/IMAG=1 constants and the FSM state enum, shared with the matrix decoder.
REQ-034 Single module; no sub-module required. The GAP pacing counter stays inline.

Verification
REQ-035 GAP=0, matrix cells set to 1..8 in index order, start pulse -> new_mtx at cycle +1, ready on cycles +2..+9 with matrix_cell=1..8 and {imag,row,col}=0..7, done at +10, busy 10 cycles.
REQ-036 GAP=2, same stimulus -> ready pulses 3 cycles apart, done at +24, busy 24 cycles.
REQ-037 Loopback into the matrix decoder: random matrix, start -> decoder done asserts and all 8 decoded cells equal the source.
REQ-038 start held high continuously -> transmissions separated by exactly one IDLE cycle; start pulses while busy produce no extra new_mtx.
REQ-039 reset asserted on the 4th cell -> all outputs 0 next cycle, no done; next start yields full new_mtx + 8 cells.
REQ-040 With MTX_ENCODER_SNAPSHOT_EN, matrix changed to all 0x7FFFF after start -> transmitted cells still equal pre-start values; without the macro, cells sent after the change read 0x7FFFF.

Source files
------------

// File: rtl/mtx_encoder_pkg.sv
// Shared definitions for the matrix serial link (encoder and decoder side):
// cell width, real/imaginary plane codes and the encoder FSM state encoding.
package mtx_encoder_pkg;

  localparam int CELL_WIDTH = 19;

  localparam logic REAL = 1'b0;
  localparam logic IMAG = 1'b1;

  localparam logic [2:0] LAST_CELL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ANNOUNCE,
    ST_SEND,
    ST_WAIT,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/mtx_encoder_if.sv
// Serial matrix link: one cell per ready pulse, tagged with its
// imag/row/col position, plus new_mtx and done framing pulses.
interface mtx_encoder_if
  import mtx_encoder_pkg::*;
#(
  parameter int WIDTH = CELL_WIDTH
) ();

  logic [WIDTH-1:0] matrix_cell;
  logic             imag;
  logic             row;
  logic             col;
  logic             ready;
  logic             new_mtx;
  logic             done;

  modport master (
    output matrix_cell, imag, row, col, ready, new_mtx, done
  );

  modport slave (
    input matrix_cell, imag, row, col, ready, new_mtx, done
  );

endinterface

// File: rtl/mtx_encoder.sv
// Serialises a 2x2 complex matrix (8 cells, index k = 4*imag + 2*row + col)
// onto the matrix link: a new_mtx pulse, 8 ready-qualified cells optionally
// spaced by GAP idle cycles, then a done pulse. All outputs are registered.
// Optional feature: define MTX_ENCODER_SNAPSHOT_EN to capture the whole
// matrix when start is accepted; otherwise cells are read live from matrix_i.
module mtx_encoder
  import mtx_encoder_pkg::*;
#(
  parameter int WIDTH = CELL_WIDTH,
  parameter int GAP   = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_i,
  input  logic [1:0][1:0][1:0][WIDTH-1:0] matrix_i,
  output logic                            busy_o,
  mtx_encoder_if.master                   link
);

  localparam logic [7:0] GAP_LIMIT = 8'(GAP);

  state_t           state_q;
  logic [2:0]       k_q;
  logic [7:0]       gap_cnt_q;
  logic             busy_q;
  logic             ready_q;
  logic             new_mtx_q;
  logic             done_q;
  logic             imag_q;
  logic             row_q;
  logic             col_q;
  logic [WIDTH-1:0] cell_q;

  logic [2:0]       next_k_d;
  logic             plane_d;
  logic [WIDTH-1:0] next_cell_d;

  logic [1:0][1:0][1:0][WIDTH-1:0] src;

`ifdef MTX_ENCODER_SNAPSHOT_EN
  logic [1:0][1:0][1:0][WIDTH-1:0] snap_q;

  // Freeze the whole matrix on the edge that accepts a new transmission
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      snap_q <= matrix_i;
    end
  end

  assign src = snap_q;
`else
  assign src = matrix_i;
`endif

  // Select the cell that will be presented at the next SEND cycle
  always_comb begin
    next_k_d    = 3'd0;
    if (state_q == ST_SEND || state_q == ST_WAIT) begin
      next_k_d = k_q + 3'd1;
    end
    plane_d     = next_k_d[2] ? IMAG : REAL;
    next_cell_d = src[plane_d][next_k_d[1]][next_k_d[0]];
  end

  // Transmission sequencer; pulse outputs default low every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      k_q       <= 3'd0;
      gap_cnt_q <= 8'd0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      new_mtx_q <= 1'b0;
      done_q    <= 1'b0;
      imag_q    <= REAL;
      row_q     <= 1'b0;
      col_q     <= 1'b0;
      cell_q    <= '0;
    end else begin
      ready_q   <= 1'b0;
      new_mtx_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_ANNOUNCE;
            busy_q    <= 1'b1;
            new_mtx_q <= 1'b1;
            k_q       <= 3'd0;
          end
        end
        ST_ANNOUNCE: begin
          state_q                 <= ST_SEND;
          k_q                     <= next_k_d;
          ready_q                 <= 1'b1;
          cell_q                  <= next_cell_d;
          {imag_q, row_q, col_q}  <= {plane_d, next_k_d[1:0]};
        end
        ST_SEND: begin
          if (k_q == LAST_CELL) begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
          end else if (GAP == 0) begin
            k_q                    <= next_k_d;
            ready_q                <= 1'b1;
            cell_q                 <= next_cell_d;
            {imag_q, row_q, col_q} <= {plane_d, next_k_d[1:0]};
          end else begin
            state_q   <= ST_WAIT;
            gap_cnt_q <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (gap_cnt_q == GAP_LIMIT) begin
            state_q                <= ST_SEND;
            gap_cnt_q              <= 8'd0;
            k_q                    <= next_k_d;
            ready_q                <= 1'b1;
            cell_q                 <= next_cell_d;
            {imag_q, row_q, col_q} <= {plane_d, next_k_d[1:0]};
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          k_q     <= 3'd0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign link.matrix_cell = cell_q;
  assign link.imag        = imag_q;
  assign link.row         = row_q;
  assign link.col         = col_q;
  assign link.ready       = ready_q;
  assign link.new_mtx     = new_mtx_q;
  assign link.done        = done_q;

endmodule

// File: tb/tb_mtx_encoder.sv
// Bench for mtx_encoder: two instances (GAP=0 and GAP=2) share one stimulus.
// A timeline model predicts every registered output from the cycle offset
// since start was accepted; directed runs also pin literal latencies/cells.
module tb_mtx_encoder;
  import mtx_encoder_pkg::*;

  localparam int W  = CELL_WIDTH;
  localparam int G0 = 0;
  localparam int G1 = 2;

  typedef logic [1:0][1:0][1:0][W-1:0] mtx_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  mtx_t matrix;
  logic busy0, busy1;

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  mtx_encoder_if #(.WIDTH(W)) link0 ();
  mtx_encoder_if #(.WIDTH(W)) link1 ();

  mtx_encoder #(.WIDTH(W), .GAP(G0)) dut0 (
    .clk(clk), .reset(reset), .start_i(start), .matrix_i(matrix),
    .busy_o(busy0), .link(link0)
  );

  mtx_encoder #(.WIDTH(W), .GAP(G1)) dut1 (
    .clk(clk), .reset(reset), .start_i(start), .matrix_i(matrix),
    .busy_o(busy1), .link(link1)
  );

  always #5 clk = ~clk;

  // Observed outputs gathered into arrays indexed by instance
  logic         oBusy[2], oNew[2], oRdy[2], oDone[2];
  logic [2:0]   oIdx[2];
  logic [W-1:0] oCell[2];

  assign oBusy[0] = busy0;
  assign oNew[0]  = link0.new_mtx;
  assign oRdy[0]  = link0.ready;
  assign oDone[0] = link0.done;
  assign oIdx[0]  = {link0.imag, link0.row, link0.col};
  assign oCell[0] = link0.matrix_cell;
  assign oBusy[1] = busy1;
  assign oNew[1]  = link1.new_mtx;
  assign oRdy[1]  = link1.ready;
  assign oDone[1] = link1.done;
  assign oIdx[1]  = {link1.imag, link1.row, link1.col};
  assign oCell[1] = link1.matrix_cell;

  function automatic int gapOf(input int d);
    return (d == 0) ? G0 : G1;
  endfunction

  // Cell j in index order (k = 4*imag + 2*row + col)
  function automatic logic [W-1:0] cellAt(input mtx_t m, input int j);
    logic [8*W-1:0] f;
    f = m;
    return f[j*W +: W];
  endfunction

  function automatic mtx_t seqMatrix();
    logic [8*W-1:0] f;
    for (int j = 0; j < 8; j++) f[j*W +: W] = W'(j + 1);
    return f;
  endfunction

  function automatic mtx_t fillMatrix(input logic [W-1:0] v);
    logic [8*W-1:0] f;
    for (int j = 0; j < 8; j++) f[j*W +: W] = v;
    return f;
  endfunction

  // Timeline model state
  bit           mBusy[2];
  int           mOff[2];
  mtx_t         mSnap[2];
  logic         expBusy[2], expNew[2], expReady[2], expDone[2];
  logic [2:0]   expIdx[2];
  logic [W-1:0] expCell[2];

  // Model: offset 1 = announce, cell j at 2 + j*(GAP+1), done at 10 + 7*GAP
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int g;
      int last;
      int j;
      g    = gapOf(d);
      last = 10 + 7 * g;
      if (reset) begin
        mBusy[d]   = 1'b0;
        mOff[d]    = 0;
        expCell[d] = '0;
        expIdx[d]  = 3'd0;
      end else if (!mBusy[d]) begin
        if (start) begin
          mBusy[d] = 1'b1;
          mOff[d]  = 1;
          mSnap[d] = matrix;
        end
      end else begin
        mOff[d]++;
        if (mOff[d] > last) mBusy[d] = 1'b0;
      end
      expBusy[d]  = mBusy[d];
      expNew[d]   = mBusy[d] && (mOff[d] == 1);
      expDone[d]  = mBusy[d] && (mOff[d] == last);
      expReady[d] = 1'b0;
      if (mBusy[d] && mOff[d] >= 2 && ((mOff[d] - 2) % (g + 1)) == 0) begin
        j = (mOff[d] - 2) / (g + 1);
        if (j <= 7) begin
          expReady[d] = 1'b1;
          expIdx[d]   = j[2:0];
`ifdef MTX_ENCODER_SNAPSHOT_EN
          expCell[d]  = cellAt(mSnap[d], j);
`else
          expCell[d]  = cellAt(matrix, j);
`endif
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic checkCycle(input int d);
    logic [W+6:0] act;
    logic [W+6:0] exp;
    act = {oBusy[d], oNew[d], oRdy[d], oDone[d], oIdx[d], oCell[d]};
    exp = {expBusy[d], expNew[d], expReady[d], expDone[d], expIdx[d], expCell[d]};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL cycle dut%0d @%0t: got busy/new/rdy/done=%b%b%b%b idx=%0d cell=%h, want %b%b%b%b idx=%0d cell=%h",
               d, $time, oBusy[d], oNew[d], oRdy[d], oDone[d], oIdx[d], oCell[d],
               expBusy[d], expNew[d], expReady[d], expDone[d], expIdx[d], expCell[d]);
    end
    total++;
    if (oNew[d] === 1'b1 && oRdy[d] === 1'b1) begin
      bad++;
      $display("[TB] FAIL exclusive dut%0d @%0t: got new_mtx=1 ready=1, want not both", d, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checkOn) begin
      for (int d = 0; d < 2; d++) checkCycle(d);
    end
  end

  // Run recordings
  int           newCnt[2], busyCnt[2], doneOff[2], doneCnt[2], nRdy[2];
  int           newOffs[2][4];
  int           rdyOff[2][8];
  logic [W-1:0] rdyCell[2][8];
  logic [2:0]   rdyIdx[2][8];

  task automatic applyStimulus(input mtx_t m);
    @(negedge clk);
    matrix = m;
    start  = 1'b1;
  endtask

  task automatic recordRun(input int cycles, input bit holdStart,
                           input bit doChange, input mtx_t changeTo);
    for (int d = 0; d < 2; d++) begin
      newCnt[d] = 0; busyCnt[d] = 0; doneOff[d] = 0; doneCnt[d] = 0; nRdy[d] = 0;
      for (int q = 0; q < 4; q++) newOffs[d][q] = 0;
    end
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      if (doChange && i == 1) matrix = changeTo;
      for (int d = 0; d < 2; d++) begin
        if (oBusy[d]) busyCnt[d]++;
        if (oNew[d]) begin
          if (newCnt[d] < 4) newOffs[d][newCnt[d]] = i;
          newCnt[d]++;
        end
        if (oDone[d]) begin
          if (doneCnt[d] == 0) doneOff[d] = i;
          doneCnt[d]++;
        end
        if (oRdy[d]) begin
          if (nRdy[d] < 8) begin
            rdyOff[d][nRdy[d]]  = i;
            rdyCell[d][nRdy[d]] = oCell[d];
            rdyIdx[d][nRdy[d]]  = oIdx[d];
          end
          nRdy[d]++;
        end
      end
    end
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      if (!oBusy[0] && !oBusy[1]) idle = 1'b1;
    end
    total++;
    if (!idle) begin
      bad++;
      $display("[TB] FAIL idle_timeout: got busy still high, want idle within 60 cycles");
    end
  endtask

  initial begin
    mtx_t rnd;
    mtx_t seq;
    bit   found;
    logic [8*W-1:0] f;

    seq    = seqMatrix();
    reset  = 1'b1;
    start  = 1'b0;
    matrix = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy0", int'(oBusy[0]), 0);
    checkOutput("reset_ready0", int'(oRdy[0]), 0);
    checkOutput("reset_cell1", int'(oCell[1]), 0);
    checkOutput("reset_idx1", int'(oIdx[1]), 0);
    checkOn = 1'b1;
    reset   = 1'b0;

    // Cells 1..8, single start pulse
    applyStimulus(seq);
    recordRun(30, 1'b0, 1'b0, '0);
    checkOutput("g0_new_off", newOffs[0][0], 1);
    checkOutput("g0_new_cnt", newCnt[0], 1);
    checkOutput("g0_busy_len", busyCnt[0], 10);
    checkOutput("g0_done_off", doneOff[0], 10);
    checkOutput("g0_cells", nRdy[0], 8);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("g0_rdy_off%0d", j), rdyOff[0][j], 2 + j);
      checkOutput($sformatf("g0_cell%0d", j), int'(rdyCell[0][j]), j + 1);
      checkOutput($sformatf("g0_idx%0d", j), int'(rdyIdx[0][j]), j);
    end
    checkOutput("g2_busy_len", busyCnt[1], 24);
    checkOutput("g2_done_off", doneOff[1], 24);
    checkOutput("g2_cells", nRdy[1], 8);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("g2_rdy_off%0d", j), rdyOff[1][j], 2 + 3 * j);
      checkOutput($sformatf("g2_cell%0d", j), int'(rdyCell[1][j]), j + 1);
    end
    waitIdle();

    // start held high: one idle cycle between back-to-back transmissions
    applyStimulus(seq);
    recordRun(34, 1'b1, 1'b0, '0);
    start = 1'b0;
    checkOutput("hold_g0_new_cnt", newCnt[0], 4);
    checkOutput("hold_g0_new2", newOffs[0][1], 12);
    checkOutput("hold_g0_new3", newOffs[0][2], 23);
    checkOutput("hold_g2_new_cnt", newCnt[1], 2);
    checkOutput("hold_g2_new2", newOffs[1][1], 26);
    waitIdle();

    // reset while the fourth cell is on the link
    applyStimulus(seq);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (oRdy[0] && oIdx[0] == 3'd3) found = 1'b1;
    end
    checkOutput("abort_found_cell3", int'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy0", int'(oBusy[0]), 0);
    checkOutput("abort_ready0", int'(oRdy[0]), 0);
    checkOutput("abort_cell0", int'(oCell[0]), 0);
    checkOutput("abort_idx0", int'(oIdx[0]), 0);
    checkOutput("abort_busy1", int'(oBusy[1]), 0);
    recordRun(12, 1'b0, 1'b0, '0);
    checkOutput("abort_no_done", doneCnt[0] + doneCnt[1], 0);
    checkOutput("abort_no_cells", nRdy[0] + nRdy[1], 0);
    applyStimulus(seq);
    recordRun(30, 1'b0, 1'b0, '0);
    checkOutput("restart_new_off", newOffs[0][0], 1);
    checkOutput("restart_cells", nRdy[0], 8);
    checkOutput("restart_first", int'(rdyCell[0][0]), 1);
    checkOutput("restart_done_off", doneOff[0], 10);
    waitIdle();

    // Random matrix loopback: reassemble cells by position
    for (int j = 0; j < 8; j++) f[j*W +: W] = W'($urandom);
    rnd = f;
    applyStimulus(rnd);
    recordRun(30, 1'b0, 1'b0, '0);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("loop_dut%0d_done", d), doneCnt[d], 1);
      for (int j = 0; j < 8; j++) begin
        checkOutput($sformatf("loop_dut%0d_cell%0d", d, rdyIdx[d][j]),
                    int'(rdyCell[d][j]), int'(cellAt(rnd, int'(rdyIdx[d][j]))));
      end
    end
    waitIdle();

    // Matrix overwritten right after start is accepted
    applyStimulus(seq);
    recordRun(30, 1'b0, 1'b1, fillMatrix(19'h7FFFF));
    for (int j = 0; j < 8; j++) begin
`ifdef MTX_ENCODER_SNAPSHOT_EN
      checkOutput($sformatf("snap_cell%0d", j), int'(rdyCell[0][j]), j + 1);
`else
      checkOutput($sformatf("live_cell%0d", j), int'(rdyCell[0][j]), 32'h7FFFF);
`endif
    end
    waitIdle();

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
